multdiv32: RTL

MULTDIV32 -- requirements
Module: multdiv32

---
 rtl/multdiv32.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/multdiv32.sv
`default_nettype none
// ============================================================================
// Module   : multdiv32
// Purpose  : Iterative 32-bit multiply/divide unit with HI/LO result registers.
//            mult/multu use shift-add (one multiplier bit per cycle); div/divu
//            use restoring division (one quotient bit per cycle). Signed ops
//            work on magnitudes and apply the sign in a final FIX cycle.
//            mthi/mtlo write HI/LO directly when the unit is idle.
// Ports    : clock           - single clock, rising edge
//            rst_n           - asynchronous active-low reset
//            MD_start        - one-cycle request strobe
//            Function_opcode - operation select (mult/multu/div/divu/mthi/mtlo)
//            Read_data_1     - rs: multiplicand / dividend / mthi-mtlo source
//            Read_data_2     - rt: multiplier / divisor
//            Busy            - high while an iterative operation is in flight
//            Done            - one-cycle pulse when HI/LO take a mult/div result
//            HI, LO          - registered result registers
// Revision : 1.0 - initial release
// ============================================================================
module multdiv32 (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        MD_start,
  input  logic [5:0]  Function_opcode,
  input  logic [31:0] Read_data_1,
  input  logic [31:0] Read_data_2,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [5:0] c_op_mult  = 6'b011000;
  localparam logic [5:0] c_op_multu = 6'b011001;
  localparam logic [5:0] c_op_div   = 6'b011010;
  localparam logic [5:0] c_op_divu  = 6'b011011;
  localparam logic [5:0] c_op_mthi  = 6'b010001;
  localparam logic [5:0] c_op_mtlo  = 6'b010011;
  localparam logic [5:0] c_last_cnt = 6'd31;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [5:0]  r_cnt;
  logic [31:0] r_opd;     // multiplicand magnitude or divisor magnitude
  logic [31:0] r_acc_hi;  // partial product high / partial remainder
  logic [31:0] r_acc_lo;  // multiplier bits / dividend bits then quotient
  logic        r_is_div;
  logic        r_neg_q;   // negate product or quotient at FIX
  logic        r_neg_r;   // negate remainder at FIX (dividend sign)
  logic        r_dz;      // divisor was zero
  logic        r_done;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  logic        w_is_mul;
  logic        w_is_div;
  logic        w_is_signed;
  logic        w_go;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_abs;
  logic [31:0] w_b_abs;

  assign w_is_mul    = (Function_opcode == c_op_mult) || (Function_opcode == c_op_multu);
  assign w_is_div    = (Function_opcode == c_op_div)  || (Function_opcode == c_op_divu);
  assign w_is_signed = (Function_opcode == c_op_mult) || (Function_opcode == c_op_div);
  assign w_go        = (r_state == S_IDLE) && MD_start && (w_is_mul || w_is_div);
  assign w_a_neg     = w_is_signed && Read_data_1[31];
  assign w_b_neg     = w_is_signed && Read_data_2[31];
  assign w_a_abs     = w_a_neg ? (32'd0 - Read_data_1) : Read_data_1;
  assign w_b_abs     = w_b_neg ? (32'd0 - Read_data_2) : Read_data_2;

  // --------------------------------------------------------------------------
  // Iteration step
  // --------------------------------------------------------------------------
  // Shift-add: add multiplicand when the current multiplier bit is set, then
  // shift the 65-bit {carry, hi, lo} right by one.
  logic [32:0] w_mul_sum;
  assign w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opd} : 33'd0);

  // Restoring divide: the shifted partial remainder can be 33 bits wide.
  logic [32:0] w_div_shift;
  logic [32:0] w_div_trial;
  logic        w_div_ge;
  assign w_div_shift = {r_acc_hi, r_acc_lo[31]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_opd});
  assign w_div_trial = w_div_shift - {1'b0, r_opd};

  // --------------------------------------------------------------------------
  // Final sign correction
  // --------------------------------------------------------------------------
  logic [63:0] w_prod;
  logic [63:0] w_prod_fix;
  logic [31:0] w_quo_fix;
  logic [31:0] w_rem_fix;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;

  assign w_prod     = {r_acc_hi, r_acc_lo};
  assign w_prod_fix = r_neg_q ? (64'd0 - w_prod) : w_prod;
  // With a zero divisor every trial subtract succeeds, so the remainder path
  // ends holding |dividend|; restoring its sign returns the original operand.
  assign w_quo_fix  = r_dz ? 32'hFFFF_FFFF : (r_neg_q ? (32'd0 - r_acc_lo) : r_acc_lo);
  assign w_rem_fix  = r_neg_r ? (32'd0 - r_acc_hi) : r_acc_hi;
  assign w_res_hi   = r_is_div ? w_rem_fix : w_prod_fix[63:32];
  assign w_res_lo   = r_is_div ? w_quo_fix : w_prod_fix[31:0];

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_go) w_state_nxt = S_RUN;
      S_RUN:   if (r_cnt == c_last_cnt) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= 6'd0;
      r_opd    <= 32'd0;
      r_acc_hi <= 32'd0;
      r_acc_lo <= 32'd0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_cnt    <= 6'd0;
            r_is_div <= w_is_div;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_dz     <= w_is_div && (Read_data_2 == 32'd0);
            r_acc_hi <= 32'd0;
            r_opd    <= w_is_div ? w_b_abs : w_a_abs;
            r_acc_lo <= w_is_div ? w_a_abs : w_b_abs;
          end else if (MD_start && (Function_opcode == c_op_mthi)) begin
            r_hi <= Read_data_1;
          end else if (MD_start && (Function_opcode == c_op_mtlo)) begin
            r_lo <= Read_data_1;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + 6'd1;
          if (r_is_div) begin
            if (w_div_ge) begin
              r_acc_hi <= w_div_trial[31:0];
              r_acc_lo <= {r_acc_lo[30:0], 1'b1};
            end else begin
              r_acc_hi <= w_div_shift[31:0];
              r_acc_lo <= {r_acc_lo[30:0], 1'b0};
            end
          end else begin
            r_acc_hi <= w_mul_sum[32:1];
            r_acc_lo <= {w_mul_sum[0], r_acc_lo[31:1]};
          end
        end
        S_FIX: begin
          r_hi   <= w_res_hi;
          r_lo   <= w_res_lo;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign Busy = (r_state != S_IDLE);
  assign Done = r_done;
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule
`default_nettype wire
